mem_port: RTL and testbench
===========================

Name: mem_port

Overview:
- Single-port memory interface between the multicycle controller and a synchronous, handshaked word memory.
- Serves instruction fetches (IRWrite) and data loads/stores (IorD, MemWrite) from the controller's datapath.
- Holds the controller via Stall until the memory acknowledges.
- Owns the instruction register (IR) and memory data register (MDR).

Parameters:
- DATA_W, 32, data word width.
- ADDR_W, 32, byte address width.
- TIMEOUT, 15, max cycles waiting for mem_ack before bus error (1..255).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- IRWrite  in  1  fetch request (from controller).
- IorD  in  1  data access request: 1 = address from ALUOut, 0 = from PC.
- MemWrite  in  1  store request (valid only with IorD=1).
- PC  in  ADDR_W  fetch address.
- ALUOut  in  ADDR_W  data address.
- WriteData  in  DATA_W  store data (register B).
- Stall  out  1  hold controller State and all datapath enables.
- IR  out  DATA_W  instruction register.
- MDR  out  DATA_W  memory data register.
- BusErr  out  1  sticky bus error.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory byte address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack.
- mem_ack  in  1  memory acknowledge, one cycle per access.

Behaviour:
- Reset values: Stall=0, IR=0, MDR=0, BusErr=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, state IDLE, wait counter 0. Reset mid-access aborts it immediately; a late mem_ack after reset is ignored.
- acc = IRWrite | IorD. Kind: FETCH if IRWrite, else STORE if MemWrite, else LOAD. If IRWrite and IorD are both set, FETCH wins.
- Stall = acc & (state != DONE) & !BusErr. It is combinational and asserts in the request cycle itself.
- State machine:
  - IDLE: if acc, latch kind, mem_addr (ALUOut if IorD else PC) and mem_wdata=WriteData, then go to BUSY. Otherwise stay.
  - BUSY: mem_req=1 and mem_we=(kind==STORE), both registered and stable until ack. Wait counter increments each cycle.
  - BUSY on mem_ack: capture mem_rdata into IR (FETCH) or MDR (LOAD); STORE captures nothing. Drop mem_req/mem_we and go to DONE.
  - BUSY on counter == TIMEOUT without ack: set BusErr, drop mem_req, go to ERR.
  - DONE: one cycle with Stall=0, so the controller advances. Next state is IDLE. A new acc in the following cycle starts a fresh access.
  - ERR: terminal until rst. Stall=0, so the controller free-runs. IR/MDR are not updated and no mem_req is issued.
- Latency with a 0-wait memory (ack in the first BUSY cycle):
  - request cycle N;
  - BUSY at N+1;
  - DONE at N+2;
  - IR/MDR valid from N+2;
  - Stall high for N and N+1.
  - Each memory wait cycle adds one cycle.
- IR/MDR hold their value except on a capture. IR is visible to the controller's Opcode decode from DONE onward.
- mem_ack outside BUSY is ignored.
- Inputs may change during BUSY; the latched address, data and kind are used.

Optional Feature:
- Macro ALIGN_CHECK_EN.
- Defined: in IDLE, if acc and the selected address[1:0] != 0, no memory request is made. BusErr sets and the FSM goes to ERR in the next cycle. Stall is high in the request cycle only.
- Undefined: address low bits pass through unchecked to mem_addr.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, BUSY, DONE, ERR, 2 bits);
  - access-kind encoding (FETCH, LOAD, STORE);
  - the DATA_W/ADDR_W defaults, reused by the controller and datapath.
- One sub-module, mem_wait_timer: resettable counter with clear/enable and an expired flag at TIMEOUT.

Test Plan:
- Fetch, 0-wait: IRWrite=1, PC=0x10, mem_rdata=0xE4000005 with ack in first BUSY cycle -> mem_addr=0x10, mem_we=0, Stall high 2 cycles, IR=0xE4000005 from DONE, MDR unchanged.
- Load, 3 waits: IorD=1, ALUOut=0x200, ack on 4th BUSY cycle with 0x1234 -> Stall high 5 cycles, MDR=0x1234, IR unchanged.
- Store: IorD=1, MemWrite=1, ALUOut=0x40, WriteData=0xCAFE; ALUOut changed mid-BUSY -> mem_we=1, mem_addr=0x40, mem_wdata=0xCAFE held until ack, no IR/MDR change.
- Timeout, TIMEOUT=15: fetch with no ack -> mem_req drops after 15 BUSY cycles, BusErr=1 sticky, Stall=0; later IRWrite issues no mem_req until rst.
- Reset mid-access: rst during BUSY, ack arrives next cycle -> all outputs at reset values, IR=0, ack ignored.
- ALIGN_CHECK_EN defined: IorD=1, ALUOut=0x42 -> mem_req never asserts, BusErr=1 next cycle. Same stimulus with the macro undefined -> normal access at 0x42.

Source files
------------

// File: rtl/mem_port_pkg.sv
// Shared types for the multicycle memory port: FSM states, access kinds and
// default bus widths reused by the controller and datapath.
package mem_port_pkg;

  localparam int unsigned DataWDef = 32;
  localparam int unsigned AddrWDef = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2,
    StErr  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    KindFetch = 2'd0,
    KindLoad  = 2'd1,
    KindStore = 2'd2
  } kind_e;

  // A fetch outranks a data access when the controller asserts both.
  function automatic kind_e sel_kind(input logic irwrite, input logic memwrite);
    if (irwrite) begin
      return KindFetch;
    end else if (memwrite) begin
      return KindStore;
    end
    return KindLoad;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter for an outstanding memory access; expired flags the
// TIMEOUT-th enabled cycle without an acknowledge.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Counter reads k-1 in the k-th busy cycle, so this fires on the TIMEOUT-th.
  assign expired = en && (count_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port.sv
// Single-port handshaked memory interface for the multicycle controller; owns IR
// and MDR. Optional ALIGN_CHECK_EN macro faults misaligned accesses instead.
module mem_port
  import mem_port_pkg::*;
#(
  parameter int unsigned DATA_W  = DataWDef,
  parameter int unsigned ADDR_W  = AddrWDef,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              IRWrite,
  input  logic              IorD,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] PC,
  input  logic [ADDR_W-1:0] ALUOut,
  input  logic [DATA_W-1:0] WriteData,
  output logic              Stall,
  output logic [DATA_W-1:0] IR,
  output logic [DATA_W-1:0] MDR,
  output logic              BusErr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  state_e              state_q, state_d;
  kind_e               kind_q, kind_d;
  logic                req_q, req_d, we_q, we_d, berr_q, berr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d, ir_q, ir_d, mdr_q, mdr_d;
  logic                acc, expired, misaligned;
  logic [ADDR_W-1:0]   sel_addr;

  assign acc      = IRWrite | IorD;
  assign sel_addr = IorD ? ALUOut : PC;

`ifdef ALIGN_CHECK_EN
  assign misaligned = |sel_addr[1:0];
`else
  assign misaligned = 1'b0;
`endif

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_q != StBusy),
    .en      (state_q == StBusy),
    .expired (expired)
  );

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ir_d    = ir_q;
    mdr_d   = mdr_q;
    berr_d  = berr_q;
    case (state_q)
      StIdle: begin
        if (acc) begin
          if (misaligned) begin
            berr_d  = 1'b1;
            state_d = StErr;
          end else begin
            kind_d  = sel_kind(IRWrite, MemWrite);
            addr_d  = sel_addr;
            wdata_d = WriteData;
            req_d   = 1'b1;
            we_d    = (sel_kind(IRWrite, MemWrite) == KindStore);
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        // An acknowledge on the final allowed cycle still completes the access.
        if (mem_ack) begin
          if (kind_q == KindFetch) begin
            ir_d = mem_rdata;
          end else if (kind_q == KindLoad) begin
            mdr_d = mem_rdata;
          end
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = StDone;
        end else if (expired) begin
          berr_d  = 1'b1;
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = StErr;
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StErr;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      kind_q  <= KindFetch;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ir_q    <= '0;
      mdr_q   <= '0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ir_q    <= ir_d;
      mdr_q   <= mdr_d;
      berr_q  <= berr_d;
    end
  end

  assign Stall     = acc && (state_q != StDone) && !berr_q;
  assign IR        = ir_q;
  assign MDR       = mdr_q;
  assign BusErr    = berr_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_port.sv
// Directed bench for mem_port: per-cycle vector table plus hand-written timeout
// and reset-abort sequences. Honours ALIGN_CHECK_EN for the 0x42 access.
module tb_mem_port;

  logic        clk = 1'b0;
  logic        rst, IRWrite, IorD, MemWrite, mem_ack;
  logic [31:0] PC, ALUOut, WriteData, mem_rdata;
  logic        Stall, BusErr, mem_req, mem_we;
  logic [31:0] IR, MDR, mem_addr, mem_wdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_port #(
    .DATA_W  (32),
    .ADDR_W  (32),
    .TIMEOUT (15)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .IRWrite   (IRWrite),
    .IorD      (IorD),
    .MemWrite  (MemWrite),
    .PC        (PC),
    .ALUOut    (ALUOut),
    .WriteData (WriteData),
    .Stall     (Stall),
    .IR        (IR),
    .MDR       (MDR),
    .BusErr    (BusErr),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  typedef struct {
    logic        r, irw, iord, mw, ack;
    logic [31:0] pc, alu, wd, rd;
    logic        st, rq, we, be;
    logic [31:0] ad, wdt, ir, mdr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic r, irw, iord, mw, ack,
                             input logic [31:0] pc, alu, wd, rd,
                             input logic st, rq, we, be,
                             input logic [31:0] ad, wdt, ir, mdr);
    vec_t x;
    x = '{r, irw, iord, mw, ack, pc, alu, wd, rd, st, rq, we, be, ad, wdt, ir, mdr};
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    IRWrite = 0; IorD = 0; MemWrite = 0; mem_ack = 0;
    PC = 0; ALUOut = 0; WriteData = 0; mem_rdata = 0;
  endtask

  localparam logic [31:0] I0 = 32'hE400_0005;

  int req_cycles;

  initial begin
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);

    //      r irw iord mw ack  pc      alu     wd       rd        st rq we be  ad      wdt      ir  mdr
    // fetch, 0 wait
    tbl.push_back(v(1, 0, 0, 0, 0, 0,     0,     0,       0,        0, 0, 0, 0, 0,     0,       0,  0));
    tbl.push_back(v(0, 1, 0, 0, 0, 'h10,  0,     0,       0,        1, 0, 0, 0, 0,     0,       0,  0));
    tbl.push_back(v(0, 1, 0, 0, 1, 'h10,  0,     0,       I0,       1, 1, 0, 0, 'h10,  0,       0,  0));
    tbl.push_back(v(0, 1, 0, 0, 0, 'h10,  0,     0,       0,        0, 0, 0, 0, 'h10,  0,       I0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0,     0,     0,       0,        0, 0, 0, 0, 'h10,  0,       I0, 0));
    // load, 3 wait cycles
    tbl.push_back(v(0, 0, 1, 0, 0, 0,     'h200, 0,       0,        1, 0, 0, 0, 'h10,  0,       I0, 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(v(0, 0, 1, 0, 0, 0,   'h200, 0,       0,        1, 1, 0, 0, 'h200, 0,       I0, 0));
    tbl.push_back(v(0, 0, 1, 0, 1, 0,     'h200, 0,       'h1234,   1, 1, 0, 0, 'h200, 0,       I0, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, 0,     'h200, 0,       0,        0, 0, 0, 0, 'h200, 0,       I0, 'h1234));
    tbl.push_back(v(0, 0, 0, 0, 0, 0,     0,     0,       0,        0, 0, 0, 0, 'h200, 0,       I0, 'h1234));
    // store, address/data changed mid-busy
    tbl.push_back(v(0, 0, 1, 1, 0, 0,     'h40,  'hCAFE,  0,        1, 0, 0, 0, 'h200, 0,       I0, 'h1234));
    tbl.push_back(v(0, 0, 1, 1, 0, 0,     'h99,  'h1111,  0,        1, 1, 1, 0, 'h40,  'hCAFE,  I0, 'h1234));
    tbl.push_back(v(0, 0, 1, 1, 1, 0,     'h99,  'h1111,  'hDEAD,   1, 1, 1, 0, 'h40,  'hCAFE,  I0, 'h1234));
    tbl.push_back(v(0, 0, 1, 1, 0, 0,     'h99,  'h1111,  0,        0, 0, 0, 0, 'h40,  'hCAFE,  I0, 'h1234));
    // stray ack while idle
    tbl.push_back(v(0, 0, 0, 0, 1, 0,     0,     0,       'hBAD,    0, 0, 0, 0, 'h40,  'hCAFE,  I0, 'h1234));
    tbl.push_back(v(0, 0, 0, 0, 0, 0,     0,     0,       0,        0, 0, 0, 0, 'h40,  'hCAFE,  I0, 'h1234));
    // load from 0x42
    tbl.push_back(v(0, 0, 1, 0, 0, 0,     'h42,  0,       0,        1, 0, 0, 0, 'h40,  'hCAFE,  I0, 'h1234));
`ifdef ALIGN_CHECK_EN
    tbl.push_back(v(0, 0, 1, 0, 1, 0,     'h42,  0,       'h5555,   0, 0, 0, 1, 'h40,  'hCAFE,  I0, 'h1234));
    tbl.push_back(v(0, 0, 1, 0, 0, 0,     'h42,  0,       0,        0, 0, 0, 1, 'h40,  'hCAFE,  I0, 'h1234));
`else
    tbl.push_back(v(0, 0, 1, 0, 1, 0,     'h42,  0,       'h5555,   1, 1, 0, 0, 'h42,  0,       I0, 'h1234));
    tbl.push_back(v(0, 0, 1, 0, 0, 0,     'h42,  0,       0,        0, 0, 0, 0, 'h42,  0,       I0, 'h5555));
`endif

    foreach (tbl[i]) begin
      @(negedge clk);
      rst = tbl[i].r; IRWrite = tbl[i].irw; IorD = tbl[i].iord; MemWrite = tbl[i].mw;
      mem_ack = tbl[i].ack; PC = tbl[i].pc; ALUOut = tbl[i].alu;
      WriteData = tbl[i].wd; mem_rdata = tbl[i].rd;
      #1;
      chk($sformatf("row%0d Stall", i),     32'(Stall),   32'(tbl[i].st));
      chk($sformatf("row%0d mem_req", i),   32'(mem_req), 32'(tbl[i].rq));
      chk($sformatf("row%0d mem_we", i),    32'(mem_we),  32'(tbl[i].we));
      chk($sformatf("row%0d BusErr", i),    32'(BusErr),  32'(tbl[i].be));
      chk($sformatf("row%0d mem_addr", i),  mem_addr,     tbl[i].ad);
      chk($sformatf("row%0d mem_wdata", i), mem_wdata,    tbl[i].wdt);
      chk($sformatf("row%0d IR", i),        IR,           tbl[i].ir);
      chk($sformatf("row%0d MDR", i),       MDR,          tbl[i].mdr);
    end

    // Timeout: fetch with no acknowledge
    @(negedge clk); rst = 1; idle_inputs();
    @(negedge clk); rst = 0; IRWrite = 1; PC = 32'h80;
    #1 chk("to req_cycle Stall", 32'(Stall), 32'd1);
    req_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (mem_req) req_cycles++;
    end
    chk("to mem_req cycles", 32'(req_cycles), 32'd15);
    chk("to BusErr", 32'(BusErr), 32'd1);
    chk("to Stall", 32'(Stall), 32'd0);
    chk("to IR", IR, 32'd0);
    @(negedge clk); IRWrite = 0;
    @(negedge clk); IRWrite = 1;
    req_cycles = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      if (mem_req) req_cycles++;
    end
    chk("err no mem_req", 32'(req_cycles), 32'd0);
    chk("err BusErr sticky", 32'(BusErr), 32'd1);

    // Reset mid-access, late ack afterwards
    @(negedge clk); rst = 1; idle_inputs();
    @(negedge clk); rst = 0; IRWrite = 1; PC = 32'h20; WriteData = 32'h77;
    @(negedge clk); #1;
    chk("ra busy mem_req", 32'(mem_req), 32'd1);
    chk("ra busy mem_addr", mem_addr, 32'h20);
    rst = 1;
    @(negedge clk); rst = 0; IRWrite = 0; mem_ack = 1; mem_rdata = 32'h777;
    #1;
    chk("ra Stall", 32'(Stall), 32'd0);
    chk("ra mem_req", 32'(mem_req), 32'd0);
    chk("ra mem_we", 32'(mem_we), 32'd0);
    chk("ra mem_addr", mem_addr, 32'd0);
    chk("ra mem_wdata", mem_wdata, 32'd0);
    chk("ra BusErr", 32'(BusErr), 32'd0);
    @(negedge clk); mem_ack = 0; #1;
    chk("ra late ack IR", IR, 32'd0);
    chk("ra late ack MDR", MDR, 32'd0);
    chk("ra late ack mem_req", 32'(mem_req), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
